// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_pkg: shared types and default constants for the run controller.
//   run_state_e  - controller FSM states
//   *_D          - default values for the cpu_run_ctrl parameters
//   STATE_W      - encoding width of run_state_e
package cpu_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_READ     = 3'd3,
    S_DONE     = 3'd4
  } run_state_e;

  localparam int          RST_CYCLES_D  = 5;
  localparam int          HALT_REPEAT_D = 4;
  localparam int          MAX_CYCLES_D  = 1000;
  localparam int          ACK_TIMEOUT_D = 16;
  localparam logic [7:0]  RESULT_ADDR_D = 8'h08;
  localparam logic [31:0] EXPECT_D      = 32'h1;

  // States in which a program execution is in flight.
  function automatic logic is_busy(input run_state_e s);
    return (s == S_RST_HOLD) || (s == S_RUN) || (s == S_READ);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: sideband read port into the core's data memory.
//   dbg_req   - read request (controller -> memory)
//   dbg_addr  - byte address of the word to read
//   dbg_ack   - read data valid this cycle (memory -> controller)
//   dbg_rdata - read data
// master: the run controller; slave: the memory debug port.
interface cpu_run_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_W     = 32
);
  logic                  dbg_req;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic                  dbg_ack;
  logic [DATA_W-1:0]     dbg_rdata;

  modport master (output dbg_req, output dbg_addr, input dbg_ack, input dbg_rdata);
  modport slave  (input dbg_req, input dbg_addr, output dbg_ack, output dbg_rdata);
endinterface

// File: rtl/cpu_run_ctrl_halt_detector.sv
// halt_detector: spots the core's terminal self-loop from the fetch PC.
//   clk, rst_n - clock, synchronous active-low reset
//   en         - high while the core is running; low clears history
//   pc         - core fetch PC, sampled every enabled cycle
//   halt       - PC has matched its previous sample HALT_REPEAT times in a row
module halt_detector #(
  parameter int PC_WIDTH    = 8,
  parameter int HALT_REPEAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt
);

  localparam int SW = $clog2(HALT_REPEAT + 1);
  localparam logic [SW-1:0] REP = SW'(HALT_REPEAT);

  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic [SW-1:0]       same_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
      same_q  <= '0;
    end else begin
      pc_q    <= pc;
      valid_q <= 1'b1;
      // The first enabled cycle has no previous sample and only loads pc_q.
      if (valid_q && (pc == pc_q))
        same_q <= (same_q == REP) ? same_q : same_q + 1'b1;
      else
        same_q <= '0;
    end
  end

  assign halt = en && (same_q == REP);

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences one program run on the rv32i core and renders
// a verdict.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - run request, honoured in IDLE or DONE only
//   pc          - core fetch PC (halt detection)
//   core_rst_n  - core n_rst, registered
//   dbg         - master side of the data-memory sideband read port
//   busy, done  - run in flight / verdict available
//   pass        - result == EXPECT and no timeout
//   timeout     - run budget or ack wait expired
//   cycle_cnt   - RUN cycles until halt or timeout (saturating)
//   result      - captured result word
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int                    PC_WIDTH    = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_W      = 32,
  parameter int                    CNT_W       = 16,
  parameter int                    RST_CYCLES  = RST_CYCLES_D,
  parameter int                    HALT_REPEAT = HALT_REPEAT_D,
  parameter int                    MAX_CYCLES  = MAX_CYCLES_D,
  parameter int                    ACK_TIMEOUT = ACK_TIMEOUT_D,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = ADDR_WIDTH'(RESULT_ADDR_D),
  parameter logic [DATA_W-1:0]     EXPECT      = DATA_W'(EXPECT_D)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                core_rst_n,
  cpu_run_ctrl_if.master      dbg,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [DATA_W-1:0]   result
);

  // A budget the counter cannot represent fires when the counter saturates.
  localparam logic [CNT_W-1:0] MAX_CNT =
    ((MAX_CYCLES >> CNT_W) != 0) ? '1 : CNT_W'(MAX_CYCLES);

  // One timer serves both the reset hold and the ack wait.
  localparam int TMR_MAX = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  run_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] result_q, result_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbg_req_q, dbg_req_d;
  logic              halt;

  halt_detector #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == S_RUN),
    .pc    (pc),
    .halt  (halt)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RST_HOLD;
          timer_d   = '0;
          cnt_d     = '0;
          result_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RST_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        // The halt cycle is still a RUN cycle, so it is counted; halt beats
        // a budget expiring in the same cycle.
        cnt_d = cnt_inc;
        if (halt) begin
          state_d = S_READ;
          timer_d = '0;
        end else if (cnt_inc == MAX_CNT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_READ: begin
        if (dbg.dbg_ack) begin
          state_d  = S_DONE;
          result_d = dbg.dbg_rdata;
          pass_d   = (dbg.dbg_rdata == EXPECT);
        end else if (timer_q == ACK_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies decoded from the next state, so they
    // line up with state_q.
    core_rst_n_d = (state_d == S_RUN) || (state_d == S_READ) || (state_d == S_DONE);
    busy_d       = is_busy(state_d);
    done_d       = (state_d == S_DONE);
    dbg_req_d    = (state_d == S_READ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dbg_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dbg_req_q    <= dbg_req_d;
    end
  end

  assign core_rst_n   = core_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycle_cnt    = cnt_q;
  assign result       = result_q;
  assign dbg.dbg_req  = dbg_req_q;
  assign dbg.dbg_addr = RESULT_ADDR;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_start = 1'b0;
  logic [7:0]  pc = '0;
  logic        core_rst_n, busy, done, pass, timeout;
  logic [15:0] cycle_cnt;
  logic [31:0] result;
  logic        s_core_rst_n, s_busy, s_done, s_pass, s_timeout;
  logic [3:0]  s_cycle_cnt;
  logic [31:0] s_result;

  int checks = 0;
  int errors = 0;
  bit saw_req;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.ADDR_WIDTH(8), .DATA_W(32)) dbg_if ();
  cpu_run_ctrl_if #(.ADDR_WIDTH(8), .DATA_W(32)) s_if ();

  cpu_run_ctrl #(.MAX_CYCLES(50)) u_dut (
    .clk (clk), .rst_n (rst_n), .start (start), .pc (pc),
    .core_rst_n (core_rst_n), .dbg (dbg_if), .busy (busy), .done (done),
    .pass (pass), .timeout (timeout), .cycle_cnt (cycle_cnt), .result (result)
  );

  // Narrow counter with an unreachable budget: timeout must fire on saturation.
  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(1000)) u_sat (
    .clk (clk), .rst_n (rst_n), .start (s_start), .pc (pc),
    .core_rst_n (s_core_rst_n), .dbg (s_if), .busy (s_busy), .done (s_done),
    .pass (s_pass), .timeout (s_timeout), .cycle_cnt (s_cycle_cnt), .result (s_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start sampled at the first edge; core reset held for 5 cycles after it.
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("core_rst_held", core_rst_n, 0);
    chk("done_cleared", done, 0);
    chk("pass_cleared", pass, 0);
    chk("timeout_cleared", timeout, 0);
    chk("cnt_cleared", cycle_cnt, 0);
    repeat (4) step();
    chk("core_rst_still_held", core_rst_n, 0);
    step();
    chk("core_rst_released", core_rst_n, 1);
  endtask

  // Ten straight-line fetches 0x00..0x24, then JAL x0,0 at 0x24.
  // First repeat at RUN sample 11, READ entered at sample 15.
  task automatic run_prog();
    for (int i = 0; i < 10; i++) begin
      pc = 8'(i * 4);
      step();
    end
    pc = 8'h24;
    repeat (4) step();
    chk("no_req_before_halt", dbg_if.dbg_req, 0);
    chk("busy_in_run", busy, 1);
    step();
    chk("req_on_halt", dbg_if.dbg_req, 1);
    chk("req_addr", dbg_if.dbg_addr, 8'h08);
    chk("cnt_at_halt", cycle_cnt, 15);
  endtask

  initial begin
    dbg_if.dbg_ack = 1'b0;
    dbg_if.dbg_rdata = '0;
    s_if.dbg_ack = 1'b0;
    s_if.dbg_rdata = '0;

    // Reset state
    repeat (2) step();
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_dbg_req", dbg_if.dbg_req, 0);
    chk("rst_dbg_addr", dbg_if.dbg_addr, 8'h08);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_start", busy, 0);

    // Nominal pass, ack after two waiting READ cycles
    start_run();
    run_prog();
    repeat (2) step();
    chk("req_held_waiting", dbg_if.dbg_req, 1);
    dbg_if.dbg_ack = 1'b1;
    dbg_if.dbg_rdata = 32'h1;
    step();
    dbg_if.dbg_ack = 1'b0;
    chk("nom_done", done, 1);
    chk("nom_pass", pass, 1);
    chk("nom_timeout", timeout, 0);
    chk("nom_result", result, 32'h1);
    chk("nom_req_dropped", dbg_if.dbg_req, 0);
    chk("nom_busy", busy, 0);
    chk("nom_core_rst_n", core_rst_n, 1);
    chk("nom_cnt", cycle_cnt, 15);

    // Rerun from DONE with a failing result word, ack on first READ cycle
    start_run();
    run_prog();
    dbg_if.dbg_ack = 1'b1;
    dbg_if.dbg_rdata = 32'h0;
    step();
    dbg_if.dbg_ack = 1'b0;
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_timeout", timeout, 0);
    chk("fail_result", result, 0);
    chk("fail_cnt_same", cycle_cnt, 15);

    // Stall of 3 repeats does not halt; 4 repeats does (READ at sample 11)
    start_run();
    pc = 8'h00; step();
    pc = 8'h04; repeat (4) step();
    pc = 8'h08; step();
    chk("stall_no_halt", dbg_if.dbg_req, 0);
    repeat (4) step();
    chk("stall_still_run", dbg_if.dbg_req, 0);
    step();
    chk("hold4_halt", dbg_if.dbg_req, 1);
    chk("hold4_cnt", cycle_cnt, 11);

    // Ack never comes: DONE after exactly 16 READ cycles
    repeat (15) step();
    chk("ackto_not_yet", done, 0);
    chk("ackto_req_held", dbg_if.dbg_req, 1);
    step();
    chk("ackto_done", done, 1);
    chk("ackto_timeout", timeout, 1);
    chk("ackto_pass", pass, 0);
    chk("ackto_req_dropped", dbg_if.dbg_req, 0);
    chk("ackto_result", result, 0);

    // Run timeout (budget 50) with a start pulse mid-RUN that must be ignored;
    // the 4-bit instance runs alongside and times out on saturation at 15.
    s_start = 1'b1;
    start_run();
    s_start = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pc = 8'(i * 4);
      start = (i == 5);
      step();
      start = 1'b0;
      saw_req |= dbg_if.dbg_req;
      if (i == 13) chk("sat_not_yet", s_done, 0);
      if (i == 14) begin
        chk("sat_done", s_done, 1);
        chk("sat_timeout", s_timeout, 1);
        chk("sat_cnt", s_cycle_cnt, 4'hF);
      end
      if (i == 48) chk("runto_not_yet", done, 0);
    end
    chk("runto_done", done, 1);
    chk("runto_timeout", timeout, 1);
    chk("runto_cnt", cycle_cnt, 50);
    chk("runto_pass", pass, 0);
    chk("runto_no_req", saw_req, 0);

    // Reset at RUN cycle 10, with a stray ack that must be ignored
    start_run();
    for (int i = 0; i < 9; i++) begin
      pc = 8'(i * 4);
      step();
    end
    rst_n = 1'b0;
    dbg_if.dbg_ack = 1'b1;
    dbg_if.dbg_rdata = 32'h1;
    step();
    chk("mid_rst_core_rst_n", core_rst_n, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", cycle_cnt, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_req", dbg_if.dbg_req, 0);
    rst_n = 1'b1;
    dbg_if.dbg_ack = 1'b0;
    step();

    // Full run after reset
    start_run();
    run_prog();
    dbg_if.dbg_ack = 1'b1;
    dbg_if.dbg_rdata = 32'h1;
    step();
    dbg_if.dbg_ack = 1'b0;
    chk("rerun_pass", pass, 1);
    chk("rerun_cnt", cycle_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences one program execution on the rv32i core, then renders a verdict. It holds the core in reset, releases it on `start`, counts cycles and detects the terminal self-loop from the fetch PC. It then reads the result word from data memory through a sideband read port and flags pass, fail or timeout. It sits between the top level (or bench/host) and the core's `n_rst`, `pc` and `d_mem` debug port. It replaces ad-hoc halt/result logic in benches and on-chip self-test.

## Interface
- `PC_WIDTH`, 8, width of core fetch PC
- `ADDR_WIDTH`, 8, data-memory byte address width
- `DATA_W`, 32, result word width
- `CNT_W`, 16, cycle counter width
- `RST_CYCLES`, 5, cycles core reset is held after `start`
- `HALT_REPEAT`, 4, consecutive unchanged PC samples that mean halt
- `MAX_CYCLES`, 1000, RUN-cycle budget before timeout
- `ACK_TIMEOUT`, 16, cycles to wait for `dbg_ack`
- `RESULT_ADDR`, 8'h08, byte address of result word
- `EXPECT`, 32'h1, value meaning pass

Ports:
- `clk`, in, 1, clock
- `rst_n`, in, 1, reset: synchronous, active-low
- `start`, in, 1, run request; sampled only in IDLE or DONE
- `pc`, in, PC_WIDTH, core fetch PC
- `core_rst_n`, out, 1, drives core `n_rst`, registered
- `dbg_req`, out, 1, result-read request
- `dbg_addr`, out, ADDR_WIDTH, read address, equals RESULT_ADDR
- `dbg_ack`, in, 1, read data valid this cycle
- `dbg_rdata`, in, DATA_W, read data
- `busy`, out, 1, high when state is not IDLE or DONE
- `done`, out, 1, high in DONE
- `pass`, out, 1, verdict, valid when `done`
- `timeout`, out, 1, run or ack timeout, valid when `done`
- `cycle_cnt`, out, CNT_W, RUN cycles until halt or timeout
- `result`, out, DATA_W, captured result word

## Operation
- FSM states: IDLE, RST_HOLD, RUN, READ, DONE.
- IDLE:
  - `core_rst_n`=0.
  - `start`=1 → RST_HOLD; clears `pass`, `timeout`, `result` and `cycle_cnt`.
- RST_HOLD:
  - `core_rst_n`=0 for exactly RST_CYCLES cycles.
  - Then → RUN.
- RUN:
  - `core_rst_n`=1.
  - `cycle_cnt` increments by 1 each cycle and saturates at 2^CNT_W−1.
  - Halt detector compares `pc` with the previous RUN sample. The first RUN cycle has no valid previous sample, so it only loads the register.
  - Match increments `same_cnt`; mismatch clears it.
  - Halt is asserted when `same_cnt` == HALT_REPEAT → READ. `cycle_cnt` freezes at that cycle's value.
  - If `cycle_cnt` reaches MAX_CYCLES without halt: `timeout`=1 → DONE; no read issued.
  - Halt and MAX_CYCLES in the same cycle: halt wins.
- READ:
  - `dbg_req`=1 with `dbg_addr`=RESULT_ADDR.
  - In the cycle `dbg_ack`=1, capture `dbg_rdata` into `result` → DONE.
  - No ack within ACK_TIMEOUT cycles: `timeout`=1 → DONE.
  - The core keeps running; it is in its self-loop and performs no stores.
- DONE:
  - `done`=1.
  - `pass` = (`result`==EXPECT) && !`timeout`.
  - `core_rst_n` stays 1.
  - `start`=1 → RST_HOLD; this is a rerun with all flags cleared.
- `start` is ignored in RST_HOLD, RUN and READ.
- `rst_n`=0 at any cycle forces IDLE and all outputs to reset values, even mid-RUN or mid-READ. An ack arriving during reset is ignored.

## Timing
- Reset values: `core_rst_n`=0, `dbg_req`=0, `dbg_addr`=RESULT_ADDR, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `cycle_cnt`=0, `result`=0.
- All outputs are registered.
- `start` high at edge N → `busy`=1 from N+1. `core_rst_n` rises at edge N+1+RST_CYCLES.
- Halt latency: a PC first repeating at RUN sample k gives READ entry at edge k+HALT_REPEAT.
- `dbg_req` stays asserted until the ack cycle inclusive and drops the cycle after.
- `done`, `pass` and `result` are valid the edge after the ack cycle.
- Ack timeout: DONE after exactly ACK_TIMEOUT READ cycles.
- `cycle_cnt` width rule: when MAX_CYCLES ≥ 2^CNT_W, the timeout fires on saturation.

## Structure
- Package `cpu_run_pkg` holds:
  - the state enum (IDLE, RST_HOLD, RUN, READ, DONE);
  - default constants RST_CYCLES_D, HALT_REPEAT_D, MAX_CYCLES_D, RESULT_ADDR_D and EXPECT_D;
  - the state-width localparam.
- Sub-module `halt_detector` holds:
  - the PC register, valid bit and `same_cnt`;
  - inputs `clk`, `rst_n`, `en`, `pc`; output `halt`.
- `en` is low outside RUN, which clears the valid bit.

## Test plan
- Nominal pass: program ends with JAL x0,0 at 0x24, mem[8]=1. After `start`, `core_rst_n` rises 5 cycles later. READ is entered HALT_REPEAT cycles after the PC first repeats at 0x24. `dbg_ack` returns 32'h1 → `done`=1, `pass`=1, `timeout`=0.
- Fail value: same flow but `dbg_rdata`=32'h0 → `pass`=0, `timeout`=0, `result`=0.
- Run timeout: `pc` increments forever with MAX_CYCLES=50 → DONE after 50 RUN cycles, `timeout`=1, `cycle_cnt`=50, `dbg_req` never asserted.
- Stall vs halt: `pc` holds for 3 cycles then advances (HALT_REPEAT=4) → no halt. It holds for 4 cycles → halt.
- Ack timeout: `dbg_ack` held low → DONE after 16 READ cycles, `timeout`=1, `pass`=0.
- Reset mid-RUN and restart:
  - `rst_n`=0 at cycle 10 of RUN → next edge all outputs at reset values, `core_rst_n`=0.
  - `start` pulse in DONE → flags clear and a full rerun completes with identical `cycle_cnt`.
  - `start` in RUN has no effect.
